cp0_timer_irq: RTL and testbench

//  Parametrised Count/Compare timer and interrupt-pending unit for CP0.
//  - Generalises the single Count/Compare pair: programmable prescaler and NUM_CMP compare channels.
//  - Adds external-interrupt synchronisers.
//  - Produces Cause.IP[7:0], Cause.TI and a masked int_pending flag for the WB exception logic.

---
 rtl/cp0_timer_irq_pkg.sv | 13 +
 rtl/cp0_timer_irq_sync_ff.sv | 36 +++
 rtl/cp0_timer_irq.sv | 123 ++++++++++++
 tb/tb_cp0_timer_irq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_timer_irq_pkg.sv
// Shared constants for the CP0 Count/Compare timer and interrupt-pending unit.
// Register numbers mirror the existing CP0 register map.
package cp0_timer_irq_pkg;

  localparam logic [4:0]  CP0_COUNT     = 5'd9;
  localparam logic [4:0]  CP0_COMPARE   = 5'd11;
  localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

  function automatic logic sel_in_range(input logic [2:0] sel, input int num_sel);
    return (32'(sel) < 32'(num_sel));
  endfunction

endpackage

// File: rtl/cp0_timer_irq_sync_ff.sv
// Generic multi-bit synchroniser chain with asynchronous active-high reset.
module sync_ff #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/cp0_timer_irq.sv
// CP0 Count/Compare timer with prescaler, NUM_CMP compare channels,
// external-interrupt synchronisers and the Cause.IP / int_pending logic.
module cp0_timer_irq
  import cp0_timer_irq_pkg::*;
#(
  parameter int COUNT_DIV   = 2,
  parameter int NUM_CMP     = 1,
  parameter int TI_LINE     = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wen,
  input  logic [4:0]         reg_num,
  input  logic [2:0]         sel,
  input  logic [31:0]        reg_in,
  output logic [31:0]        reg_out,
  output logic               reg_hit,
  input  logic [5:0]         interrupt,
  input  logic [1:0]         sw_ip,
  input  logic [7:0]         status_im,
  input  logic               status_ie,
  input  logic               status_exl,
  output logic [7:0]         cause_ip,
  output logic               cause_ti,
  output logic [NUM_CMP-1:0] ti_vec,
  output logic               int_pending
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic          tick, count_wr;
  logic [31:0]   compare_val [NUM_CMP];
  logic [5:0]    s_int;
  logic [7:0]    cause_ip_q, cause_ip_d;

  assign tick     = (presc_q == PRESC_LAST);
  assign count_wr = wen && (reg_num == CP0_COUNT) && (sel == 3'd0);

  // A Count write restarts the prescaler so the new value is held a full period.
  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick || count_wr) presc_d = '0;
    count_d = count_q;
    if (count_wr)  count_d = reg_in;
    else if (tick) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  for (genvar k = 0; k < NUM_CMP; k++) begin : g_cmp
    logic        cmp_wr;
    logic [31:0] cmp_q, cmp_d;
    logic        ti_q, ti_d;

    assign cmp_wr = wen && (reg_num == CP0_COMPARE) && (sel == 3'(k));

    always_comb begin
      cmp_d = cmp_wr ? reg_in : cmp_q;
      ti_d  = cmp_wr ? 1'b0 : (ti_q | (count_q == cmp_q));
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cmp_q <= COMPARE_RESET;
        ti_q  <= 1'b0;
      end else begin
        cmp_q <= cmp_d;
        ti_q  <= ti_d;
      end
    end

    assign compare_val[k] = cmp_q;
    assign ti_vec[k]      = ti_q;
  end

  sync_ff #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (interrupt),
    .q     (s_int)
  );

  always_comb begin
    cause_ip_d          = {s_int, sw_ip};
    cause_ip_d[TI_LINE] = cause_ip_d[TI_LINE] | (|ti_vec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cause_ip_q <= '0;
    else       cause_ip_q <= cause_ip_d;
  end

  assign cause_ip    = cause_ip_q;
  assign cause_ti    = |ti_vec;
  assign int_pending = status_ie & ~status_exl & (|(cause_ip_q & status_im));

  always_comb begin
    reg_hit = 1'b0;
    reg_out = '0;
    if ((reg_num == CP0_COUNT) && (sel == 3'd0)) begin
      reg_hit = 1'b1;
      reg_out = count_q;
    end else if ((reg_num == CP0_COMPARE) && sel_in_range(sel, NUM_CMP)) begin
      reg_hit = 1'b1;
      for (int k = 0; k < NUM_CMP; k++) begin
        if (sel == 3'(k)) reg_out = compare_val[k];
      end
    end
  end

endmodule

// File: tb/tb_cp0_timer_irq.sv
// Self-checking bench for cp0_timer_irq: directed scenarios plus random MTC0/interrupt
// traffic, all compared every cycle against a cycle-count based behavioural model.
module tb_cp0_timer_irq;
  import cp0_timer_irq_pkg::*;

  localparam int DIV  = 2;
  localparam int NCMP = 2;
  localparam int TIL  = 7;
  localparam int SS   = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wen = 1'b0;
  logic [4:0]      reg_num = '0;
  logic [2:0]      sel = '0;
  logic [31:0]     reg_in = '0;
  logic [5:0]      interrupt = '0;
  logic [1:0]      sw_ip = '0;
  logic [7:0]      status_im = '0;
  logic            status_ie = 1'b0;
  logic            status_exl = 1'b0;
  logic [31:0]     reg_out;
  logic            reg_hit;
  logic [7:0]      cause_ip;
  logic            cause_ti;
  logic [NCMP-1:0] ti_vec;
  logic            int_pending;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_timer_irq #(.COUNT_DIV(DIV), .NUM_CMP(NCMP), .TI_LINE(TIL), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .reset       (reset),
    .wen         (wen),
    .reg_num     (reg_num),
    .sel         (sel),
    .reg_in      (reg_in),
    .reg_out     (reg_out),
    .reg_hit     (reg_hit),
    .interrupt   (interrupt),
    .sw_ip       (sw_ip),
    .status_im   (status_im),
    .status_ie   (status_ie),
    .status_exl  (status_exl),
    .cause_ip    (cause_ip),
    .cause_ti    (cause_ti),
    .ti_vec      (ti_vec),
    .int_pending (int_pending)
  );

  always #5 clk = ~clk;

  // Count is modelled as base value plus elapsed clocks divided by the prescale factor.
  logic [31:0]     m_base;
  longint          m_n;
  logic [31:0]     m_cmp [NCMP];
  logic [NCMP-1:0] m_ti;
  logic [7:0]      m_cause;
  logic [5:0]      m_hist [$];

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_n / DIV);
  endfunction

  task automatic model_reset();
    m_base  = '0;
    m_n     = 0;
    for (int k = 0; k < NCMP; k++) m_cmp[k] = 32'hFFFF_FFFF;
    m_ti    = '0;
    m_cause = '0;
    m_hist  = {};
    for (int i = 0; i < SS; i++) m_hist.push_back(6'd0);
  endtask

  task automatic model_edge();
    logic [31:0]     c;
    logic [NCMP-1:0] ti_new;
    if (reset) begin
      model_reset();
      return;
    end
    c = m_count();
    for (int k = 0; k < NCMP; k++) begin
      ti_new[k] = m_ti[k] | (c == m_cmp[k]);
      if (wen && reg_num == CP0_COMPARE && sel == 3'(k)) begin
        ti_new[k] = 1'b0;
        m_cmp[k]  = reg_in;
      end
    end
    m_cause = {m_hist[0], sw_ip};
    if (|m_ti) m_cause[TIL] = 1'b1;
    m_ti = ti_new;
    if (wen && reg_num == CP0_COUNT && sel == 3'd0) begin
      m_base = reg_in;
      m_n    = 0;
    end else begin
      m_n++;
    end
    void'(m_hist.pop_front());
    m_hist.push_back(interrupt);
  endtask

  function automatic logic exp_hit();
    return (reg_num == CP0_COUNT && sel == 3'd0) ||
           (reg_num == CP0_COMPARE && int'(sel) < NCMP);
  endfunction

  function automatic logic [31:0] exp_reg_out();
    if (reg_num == CP0_COUNT && sel == 3'd0) return m_count();
    if (reg_num == CP0_COMPARE) begin
      for (int k = 0; k < NCMP; k++) if (int'(sel) == k) return m_cmp[k];
    end
    return 32'd0;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_output("reg_out", reg_out, exp_reg_out());
    check_output("reg_hit", 32'(reg_hit), 32'(exp_hit()));
    check_output("cause_ip", 32'(cause_ip), 32'(m_cause));
    check_output("cause_ti", 32'(cause_ti), 32'(|m_ti));
    check_output("ti_vec", 32'(ti_vec), 32'(m_ti));
    check_output("int_pending", 32'(int_pending),
                 32'(status_ie & ~status_exl & (|(m_cause & status_im))));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic apply_stimulus(input logic [4:0] rn, input logic [2:0] s, input logic [31:0] d);
    wen = 1'b1; reg_num = rn; sel = s; reg_in = d;
    step();
    wen = 1'b0;
  endtask

  task automatic read_addr(input logic [4:0] rn, input logic [2:0] s);
    reg_num = rn; sel = s;
    #1;
    compare_all();
  endtask

  initial begin
    int guard;
    logic [1:0] pick;

    model_reset();
    #2 reset = 1'b1;
    #1;
    compare_all();
    check_output("reset_cause_ip", 32'(cause_ip), 32'd0);
    step();
    step();
    reset = 1'b0;

    // Prescaled count after reset.
    read_addr(CP0_COUNT, 3'd0);
    repeat (10) step();
    check_output("count_after_10", reg_out, 32'd5);
    check_output("idle_cause_ip", 32'(cause_ip), 32'd0);
    check_output("idle_int_pending", 32'(int_pending), 32'd0);

    // Wrap-around.
    apply_stimulus(CP0_COUNT, 3'd0, 32'hFFFF_FFFE);
    repeat (2) step();
    check_output("count_ffffffff", reg_out, 32'hFFFF_FFFF);
    repeat (2) step();
    check_output("count_wrap_0", reg_out, 32'd0);

    // Single-channel match, cause, int_pending, clear.
    apply_stimulus(CP0_COMPARE, 3'd1, 32'hFFFF_FFFF);
    apply_stimulus(CP0_COUNT, 3'd0, 32'd100);
    apply_stimulus(CP0_COMPARE, 3'd0, 32'd102);
    repeat (3) step();
    check_output("ti_before_match", 32'(ti_vec), 32'd0);
    step();
    check_output("ti_at_match", 32'(ti_vec), 32'd1);
    step();
    check_output("cause_ip7_set", 32'(cause_ip[7]), 32'd1);
    status_ie = 1'b1; status_exl = 1'b0; status_im = 8'h80;
    #1;
    compare_all();
    check_output("int_pending_ti", 32'(int_pending), 32'd1);
    apply_stimulus(CP0_COMPARE, 3'd0, 32'hFFFF_FFFF);
    check_output("ti_cleared", 32'(ti_vec), 32'd0);
    step();
    check_output("cause_ip7_clear", 32'(cause_ip[7]), 32'd0);
    status_ie = 1'b0; status_im = 8'h00;

    // Two channels.
    apply_stimulus(CP0_COUNT, 3'd0, 32'd10);
    apply_stimulus(CP0_COMPARE, 3'd0, 32'd50);
    apply_stimulus(CP0_COMPARE, 3'd1, 32'd20);
    read_addr(CP0_COUNT, 3'd0);
    guard = 0;
    while (ti_vec == '0 && guard < 200) begin step(); guard++; end
    check_output("ti_ch1_first", 32'(ti_vec), 32'b10);
    guard = 0;
    while (ti_vec != 2'b11 && guard < 200) begin step(); guard++; end
    check_output("ti_both", 32'(ti_vec), 32'b11);
    apply_stimulus(CP0_COMPARE, 3'd1, 32'd70);
    guard = 0;
    while (m_count() != 32'd70 && guard < 200) begin step(); guard++; end
    guard = 0;
    while (m_count() == 32'd70 && guard < 10) begin
      apply_stimulus(CP0_COMPARE, 3'd1, 32'd70);
      guard++;
    end
    repeat (3) step();
    check_output("ti1_write_wins", 32'(ti_vec[1]), 32'd0);
    apply_stimulus(CP0_COMPARE, 3'd2, 32'd123);
    check_output("sel2_no_hit", 32'(reg_hit), 32'd0);
    check_output("sel2_reads_0", reg_out, 32'd0);
    read_addr(CP0_COMPARE, 3'd0);
    check_output("cmp0_kept", reg_out, 32'd50);

    // External interrupt latency and masking.
    status_ie = 1'b1; status_exl = 1'b1; status_im = 8'h10;
    interrupt = 6'b000100;
    step();
    interrupt = 6'b000000;
    check_output("irq_lat1", 32'(cause_ip[4]), 32'd0);
    step();
    check_output("irq_lat2", 32'(cause_ip[4]), 32'd0);
    step();
    check_output("irq_lat3", 32'(cause_ip[4]), 32'd1);
    check_output("irq_exl_masked", 32'(int_pending), 32'd0);
    status_exl = 1'b0; status_im = 8'h00;
    interrupt = 6'b000100;
    step();
    interrupt = 6'b000000;
    repeat (2) step();
    check_output("irq_im_masked", 32'(int_pending), 32'd0);
    status_im = 8'h10;
    #1;
    compare_all();
    check_output("irq_unmasked", 32'(int_pending), 32'd1);
    step();
    status_ie = 1'b0; status_im = 8'h00;

    // Async reset with a pending timer flag.
    read_addr(CP0_COUNT, 3'd0);
    check_output("ti_before_reset", 32'(ti_vec), 32'b01);
    #3 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_output("rst_ti_vec", 32'(ti_vec), 32'd0);
    check_output("rst_cause_ip", 32'(cause_ip), 32'd0);
    check_output("rst_count", reg_out, 32'd0);
    step();
    reset = 1'b0;
    read_addr(CP0_COMPARE, 3'd0);
    check_output("rst_cmp0", reg_out, 32'hFFFF_FFFF);

    // Random traffic.
    for (int t = 0; t < 2000; t++) begin
      wen  = ($urandom_range(0, 5) == 0);
      pick = 2'($urandom_range(0, 3));
      case (pick)
        2'd0:    reg_num = CP0_COUNT;
        2'd3:    reg_num = 5'($urandom);
        default: reg_num = CP0_COMPARE;
      endcase
      sel = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 3));
      if (reg_num == CP0_COMPARE)
        reg_in = m_count() + 32'($urandom_range(0, 8));
      else if ($urandom_range(0, 1) == 0)
        reg_in = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        reg_in = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) interrupt = 6'($urandom);
      sw_ip      = 2'($urandom);
      status_im  = 8'($urandom);
      status_ie  = 1'($urandom);
      status_exl = ($urandom_range(0, 3) == 0);
      step();
    end
    wen = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
